// File: rtl/instructions_pkg.sv
// Shared instruction constants and helpers
// for the front-end pipeline stages.
package instructions_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and
// occupancy count, used for fetch queues.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_push && !i_flush)
      r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(i_push)
               - CW'(i_pop);
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, in-order imem
// requests, response buffer, redirect.
module fetch_stage
  import instructions_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] Instruction,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_pls4
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [XLEN-1:0]   r_fetch_pc;
  logic [CW-1:0]     r_out;
  logic [CW-1:0]     r_drop;
  logic [CW-1:0]     w_pcq_cnt;
  logic [CW-1:0]     w_buf_cnt;
  logic [CW:0]       w_credit;
  logic [XLEN-1:0]   w_pcq_head;
  logic [2*XLEN-1:0] w_buf_head;
  logic              w_accept;
  logic              w_take;
  logic              w_pop;

  // stale (dropped) requests still hold credit
  assign w_credit = {1'b0, r_out}
                  + {1'b0, w_buf_cnt};

  assign imem_req  = rstn && !redirect_valid &&
                     (w_credit < (CW+1)'(BUF_DEPTH));
  assign imem_addr = r_fetch_pc;
  assign w_accept  = imem_req && imem_ready;

  assign w_take = imem_rvalid && !redirect_valid &&
                  (r_drop == '0) &&
                  (w_pcq_cnt != '0);

  assign inst_valid = (w_buf_cnt != '0);
  assign w_pop = inst_valid && inst_ready &&
                 !redirect_valid;

  assign pc = inst_valid ?
              w_buf_head[2*XLEN-1:XLEN] : '0;
  assign Instruction = inst_valid ?
              w_buf_head[XLEN-1:0] :
              XLEN'(NOP_INST);
  assign pc_pls4 = pc + XLEN'(4);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fetch_pc <= RESET_PC;
      r_out      <= '0;
      r_drop     <= '0;
    end else begin
      r_out <= r_out + CW'(w_accept)
             - CW'(imem_rvalid);
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc & ~XLEN'(3);
        // every request still in flight is stale
        r_drop <= r_out - CW'(imem_rvalid);
      end else begin
        if (w_accept)
          r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (imem_rvalid && r_drop != '0)
          r_drop <= r_drop - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .W     (XLEN),
    .DEPTH (BUF_DEPTH)
  ) u_pcq (
    .clk     (clk),
    .rst_n   (rstn),
    .i_flush (redirect_valid),
    .i_push  (w_accept),
    .i_data  (r_fetch_pc),
    .i_pop   (w_take),
    .o_data  (w_pcq_head),
    .o_count (w_pcq_cnt)
  );

  fetch_fifo #(
    .W     (2*XLEN),
    .DEPTH (BUF_DEPTH)
  ) u_ibuf (
    .clk     (clk),
    .rst_n   (rstn),
    .i_flush (redirect_valid),
    .i_push  (w_take),
    .i_data  ({w_pcq_head, imem_rdata}),
    .i_pop   (w_pop),
    .o_data  (w_buf_head),
    .o_count (w_buf_cnt)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against
// a queue-based fetch/memory reference.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] Instruction;
  logic [31:0] pc;
  logic [31:0] pc_pls4;

  fetch_stage #(
    .XLEN      (32),
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .Instruction    (Instruction),
    .pc             (pc),
    .pc_pls4        (pc_pls4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  req_t        memq[$];
  ent_t        expq[$];
  logic [31:0] m_pc;
  int          m_epoch;
  int          cyc;
  int          acc_cnt;
  int          lat_min;
  int          lat_max;
  int          checks;
  int          errors;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdata(
    input logic [31:0] a
  );
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic step(
    input int          pr,
    input int          pv,
    input int          pi,
    input int          pd,
    input logic [31:0] tgt,
    input bit          rnd_tgt
  );
    req_t r;
    bit   acc;
    @(negedge clk);
    redirect_valid = ($urandom_range(99) < pd);
    redirect_pc = rnd_tgt ?
                  ($urandom & 32'h0000_03ff) : tgt;
    imem_ready  = ($urandom_range(99) < pr);
    inst_ready  = ($urandom_range(99) < pi);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (memq.size() > 0 && memq[0].due <= cyc &&
        $urandom_range(99) < pv) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mdata(memq[0].addr);
    end
    #1;
    check("req", imem_req,
          !redirect_valid &&
          (memq.size() + expq.size() < 4));
    check("valid", inst_valid, expq.size() > 0);
    if (expq.size() > 0) begin
      check("pc", pc, expq[0].pc);
      check("inst", Instruction, expq[0].inst);
      check("pc4", pc_pls4, expq[0].pc + 32'd4);
    end else begin
      check("nop", Instruction, NOP);
    end
    acc = imem_req && imem_ready;
    if (acc) begin
      check("addr", imem_addr, m_pc);
      acc_cnt++;
    end
    if (!redirect_valid && inst_ready &&
        expq.size() > 0)
      void'(expq.pop_front());
    if (imem_rvalid) begin
      r = memq.pop_front();
      if (!redirect_valid && r.epoch == m_epoch)
        expq.push_back('{pc: r.addr,
                         inst: mdata(r.addr)});
    end
    if (redirect_valid) begin
      expq.delete();
      m_epoch++;
      m_pc = redirect_pc & ~32'd3;
    end
    if (acc) begin
      memq.push_back('{addr: imem_addr,
        epoch: m_epoch,
        due: cyc + $urandom_range(lat_max, lat_min)});
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic stream(input int n);
    repeat (n) step(100, 100, 100, 0, 32'h0, 1'b0);
  endtask

  task automatic redirect_to(input logic [31:0] t);
    step(100, 100, 100, 100, t, 1'b0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    rstn           = 1'b0;
    redirect_valid = 1'b0;
    imem_ready     = 1'b0;
    imem_rvalid    = 1'b0;
    inst_ready     = 1'b0;
    #1;
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_valid", inst_valid, 1'b0);
    check("rst_nop", Instruction, NOP);
    memq.delete();
    expq.delete();
    m_pc = RST_PC;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int a0;
    checks = 0;
    errors = 0;
    cyc = 0;
    acc_cnt = 0;
    m_epoch = 0;
    m_pc = RST_PC;
    lat_min = 1;
    lat_max = 1;
    rstn = 1'b0;
    imem_ready = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b0;
    #1;
    check("r_req", imem_req, 1'b0);
    check("r_addr", imem_addr, RST_PC);
    check("r_valid", inst_valid, 1'b0);
    check("r_inst", Instruction, NOP);
    check("r_pc", pc, 32'h0);
    check("r_pc4", pc_pls4, 32'h4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    stream(20);

    redirect_to(32'h0);
    a0 = acc_cnt;
    repeat (12) step(100, 100, 0, 0, 32'h0, 1'b0);
    check("full_acc", acc_cnt - a0, 4);
    check("full_req", imem_req, 1'b0);
    stream(10);

    lat_min = 3;
    lat_max = 3;
    stream(4);
    redirect_to(32'h100);
    stream(12);

    lat_min = 1;
    lat_max = 1;
    stream(5);
    redirect_to(32'h200);
    stream(8);

    redirect_to(32'hffff_fff9);
    stream(8);

    lat_min = 1;
    lat_max = 4;
    repeat (1500)
      step(70, 70, 60, 5, 32'h0, 1'b1);

    lat_min = 1;
    lat_max = 2;
    stream(6);
    mid_reset();
    stream(10);
    repeat (500)
      step(80, 80, 70, 4, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
